// File: rtl/decoder_stage_controller_pkg.sv
// Shared decoder definitions: stage codes broadcast to the node/link array.
package decoder_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  typedef enum logic [STAGE_WIDTH-1:0] {
    STAGE_IDLE   = 3'd0,
    STAGE_INIT   = 3'd1,
    STAGE_GROW   = 3'd2,
    STAGE_MERGE  = 3'd3,
    STAGE_RESULT = 3'd4
  } stage_e;

endpackage

// File: rtl/decoder_stage_controller_if.sv
// Controller <-> array/consumer signal bundle.
interface decoder_stage_controller_if
  import decoder_stage_controller_pkg::*;
#(
  parameter int ITER_W = 5
);

  logic                   start;
  logic                   busy;
  logic                   any_odd_cluster;
  logic                   result_ack;
  logic [STAGE_WIDTH-1:0] stage;
  logic                   initialize;
  logic                   grow_pulse;
  logic [ITER_W-1:0]      iteration;
  logic                   result_valid;
  logic                   timeout;

  modport master (
    input  start, busy, any_odd_cluster, result_ack,
    output stage, initialize, grow_pulse,
    output iteration, result_valid, timeout
  );

  modport slave (
    output start, busy, any_odd_cluster, result_ack,
    input  stage, initialize, grow_pulse,
    input  iteration, result_valid, timeout
  );

endinterface

// File: rtl/decoder_stage_controller_settle_counter.sv
// Counts consecutive quiet cycles; settled on the last one of the window.
module settle_counter #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic busy,
  output logic settled
);

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] count;

  assign settled = !clear && !busy && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || busy || settled) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/decoder_stage_controller.sv
// Sequences INIT/GROW/MERGE rounds of a decode and reports the result.
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int MAX_ITER      = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          busy,
  input  logic                          any_odd_cluster,
  input  logic                          result_ack,
  output logic [STAGE_WIDTH-1:0]        stage,
  output logic                          initialize,
  output logic                          grow_pulse,
  output logic [$clog2(MAX_ITER+1)-1:0] iteration,
  output logic                          result_valid,
  output logic                          timeout
);

  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  stage_e state;
  logic   settled;

  assign stage = state;

  settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state != STAGE_MERGE),
    .busy    (busy),
    .settled (settled)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= STAGE_IDLE;
      initialize   <= 1'b0;
      grow_pulse   <= 1'b0;
      iteration    <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      initialize <= 1'b0;
      grow_pulse <= 1'b0;
      unique case (state)
        STAGE_IDLE: begin
          if (start) begin
            state      <= STAGE_INIT;
            initialize <= 1'b1;
            iteration  <= '0;
            timeout    <= 1'b0;
          end
        end
        STAGE_INIT: begin
          state      <= STAGE_GROW;
          grow_pulse <= 1'b1;
        end
        STAGE_GROW: begin
          state <= STAGE_MERGE;
          if (iteration < ITER_MAX) begin
            iteration <= iteration + ITER_W'(1);
          end
        end
        STAGE_MERGE: begin
          if (settled) begin
            priority case (1'b1)
              !any_odd_cluster: begin
                state        <= STAGE_RESULT;
                result_valid <= 1'b1;
                timeout      <= 1'b0;
              end
              (iteration < ITER_MAX): begin
                state      <= STAGE_GROW;
                grow_pulse <= 1'b1;
              end
              default: begin
                state        <= STAGE_RESULT;
                result_valid <= 1'b1;
                timeout      <= 1'b1;
              end
            endcase
          end
        end
        STAGE_RESULT: begin
          if (result_ack) begin
            state        <= STAGE_IDLE;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= STAGE_IDLE;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Directed bench for decoder_stage_controller (default and MAX_ITER=2).
module tb_decoder_stage_controller;

  logic clk;
  logic reset_n;
  logic start_a;
  logic start_b;
  logic busy;
  logic odd;
  logic ack;

  int n_run;
  int n_fail;

  decoder_stage_controller_if #(.ITER_W(5)) ifa ();
  decoder_stage_controller_if #(.ITER_W(2)) ifb ();

  assign ifa.start           = start_a;
  assign ifa.busy            = busy;
  assign ifa.any_odd_cluster = odd;
  assign ifa.result_ack      = ack;
  assign ifb.start           = start_b;
  assign ifb.busy            = busy;
  assign ifb.any_odd_cluster = odd;
  assign ifb.result_ack      = ack;

  decoder_stage_controller dut_a (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (ifa.start),
    .busy            (ifa.busy),
    .any_odd_cluster (ifa.any_odd_cluster),
    .result_ack      (ifa.result_ack),
    .stage           (ifa.stage),
    .initialize      (ifa.initialize),
    .grow_pulse      (ifa.grow_pulse),
    .iteration       (ifa.iteration),
    .result_valid    (ifa.result_valid),
    .timeout         (ifa.timeout)
  );

  decoder_stage_controller #(
    .MAX_ITER(2)
  ) dut_b (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (ifb.start),
    .busy            (ifb.busy),
    .any_odd_cluster (ifb.any_odd_cluster),
    .result_ack      (ifb.result_ack),
    .stage           (ifb.stage),
    .initialize      (ifb.initialize),
    .grow_pulse      (ifb.grow_pulse),
    .iteration       (ifb.iteration),
    .result_valid    (ifb.result_valid),
    .timeout         (ifb.timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one decode; odd clears once odd_grows grow pulses have been seen.
  task automatic run_decode(input bit sel, input int odd_grows,
                            input logic [31:0] busy_mask,
                            output int cycles, output int gp);
    logic rv;
    odd = (odd_grows > 0);
    busy = 1'b0;
    if (sel) start_b = 1'b1;
    else start_a = 1'b1;
    cycles = 0;
    gp = 0;
    rv = 1'b0;
    while (!rv && cycles < 300) begin
      step();
      start_a = 1'b0;
      start_b = 1'b0;
      cycles++;
      if (sel ? ifb.grow_pulse : ifa.grow_pulse) gp++;
      if (gp >= odd_grows) odd = 1'b0;
      busy = (cycles < 32) ? busy_mask[cycles] : 1'b0;
      if (cycles == 2 || cycles == 4) begin
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
      end
      rv = sel ? ifb.result_valid : ifa.result_valid;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    busy = 1'b0;
    check("run_done", 32'(rv), 1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  int cyc;
  int gp;

  initial begin
    n_run = 0;
    n_fail = 0;
    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    busy = 1'b0;
    odd = 1'b0;
    ack = 1'b0;
    #1;
    check("rst_stage", 32'(ifa.stage), 0);
    check("rst_outs", {ifa.initialize, ifa.grow_pulse,
                       ifa.result_valid, ifa.timeout}, 0);
    check("rst_iter", 32'(ifa.iteration), 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Plain decode with walk-through of first stages
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("init_stage", 32'(ifa.stage), 1);
    check("init_pulse", 32'(ifa.initialize), 1);
    step();
    check("grow_stage", 32'(ifa.stage), 2);
    check("grow_pulse", {ifa.initialize, ifa.grow_pulse}, 1);
    step();
    check("merge_stage", 32'(ifa.stage), 3);
    check("merge_iter", 32'(ifa.iteration), 1);
    do_ack();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    step();

    run_decode(0, 0, 0, cyc, gp);
    check("basic_cycles", cyc, 7);
    check("basic_iter", 32'(ifa.iteration), 1);
    check("basic_tmo", 32'(ifa.timeout), 0);
    check("basic_stage", 32'(ifa.stage), 4);

    start_a = 1'b1;
    do_ack();
    start_a = 1'b0;
    check("ack_idle", 32'(ifa.stage), 0);
    check("ack_rv", 32'(ifa.result_valid), 0);
    step();
    check("no_b2b", 32'(ifa.stage), 0);
    check("hold_iter", 32'(ifa.iteration), 1);

    run_decode(0, 0, 32'h28, cyc, gp);
    check("busy_13_cycles", cyc, 10);
    do_ack();

    run_decode(0, 0, 32'h40, cyc, gp);
    check("busy_last_cycles", cyc, 11);
    do_ack();

    run_decode(0, 3, 0, cyc, gp);
    check("odd2_grows", gp, 3);
    check("odd2_iter", 32'(ifa.iteration), 3);
    check("odd2_tmo", 32'(ifa.timeout), 0);
    check("odd2_cycles", cyc, 17);
    do_ack();

    run_decode(1, 1000, 0, cyc, gp);
    check("max_grows", gp, 2);
    check("max_iter", 32'(ifb.iteration), 2);
    check("max_tmo", 32'(ifb.timeout), 1);
    check("max_cycles", cyc, 12);
    do_ack();
    odd = 1'b0;
    step();
    check("max_hold_stage", 32'(ifb.stage), 0);
    check("max_hold_iter", 32'(ifb.iteration), 2);
    check("max_hold_tmo", 32'(ifb.timeout), 1);

    // Async reset in MERGE of the third round
    odd = 1'b1;
    start_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      start_a = 1'b0;
      if (ifa.iteration == 3 && ifa.stage == 3) break;
    end
    check("pre_rst_iter", 32'(ifa.iteration), 3);
    check("pre_rst_stage", 32'(ifa.stage), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_stage", 32'(ifa.stage), 0);
    check("arst_iter", 32'(ifa.iteration), 0);
    check("arst_outs", {ifa.initialize, ifa.grow_pulse,
                        ifa.result_valid, ifa.timeout}, 0);
    odd = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    check("post_rst_idle", 32'(ifa.stage), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
